// File: rtl/pipelined_n_bits_subtractor_module_pkg.sv
// Shared types and constants for the pipelined ARM-style subtractor.
// Subtract mode encoding, flag bit positions and a flag packing helper.
package pipelined_n_bits_subtractor_module_pkg;

    typedef enum logic [1:0] {
        SUB = 2'b00,
        RSB = 2'b01,
        SBC = 2'b10,
        RSC = 2'b11
    } sub_mode_t;

    localparam int unsigned NUM_FLAGS = 4;
    localparam int unsigned FLAG_N    = 3;
    localparam int unsigned FLAG_Z    = 2;
    localparam int unsigned FLAG_C    = 1;
    localparam int unsigned FLAG_V    = 0;

    function automatic logic [NUM_FLAGS-1:0] pack_flags(
        input logic n,
        input logic z,
        input logic c,
        input logic v
    );
        logic [NUM_FLAGS-1:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/pipelined_n_bits_subtractor_module_if.sv
// Valid/ready operand and result bus of the pipelined subtractor.
// The master drives operands and result-ready; the slave is the subtractor.
interface pipelined_n_bits_subtractor_module_if #(
    parameter int unsigned BITS = 32
);
    import pipelined_n_bits_subtractor_module_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [BITS-1:0]      A;
    logic [BITS-1:0]      B;
    sub_mode_t            mode;
    logic                 c_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [BITS-1:0]      Diff;
    logic                 Bout;
    logic [NUM_FLAGS-1:0] flags;

    modport master (
        output in_valid, A, B, mode, c_in, out_ready,
        input  in_ready, out_valid, Diff, Bout, flags
    );

    modport slave (
        input  in_valid, A, B, mode, c_in, out_ready,
        output in_ready, out_valid, Diff, Bout, flags
    );

endinterface

// File: rtl/pipelined_n_bits_subtractor_module_chunk_stage.sv
// One pipeline stage: subtracts chunk Index with borrow-in and registers the
// partial difference, borrow-out and the operands for the stages above it.
module sub_chunk_stage
    import pipelined_n_bits_subtractor_module_pkg::*;
#(
    parameter int unsigned Bits  = 32,
    parameter int unsigned Chunk = 8,
    parameter int unsigned Index = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 valid_i,
    input  logic [Bits-1:0]      x_i,
    input  logic [Bits-1:0]      y_i,
    input  logic [Bits-1:0]      diff_i,
    input  logic                 borrow_i,
    output logic                 valid_o,
    output logic [Bits-1:0]      x_o,
    output logic [Bits-1:0]      y_o,
    output logic [Bits-1:0]      diff_o,
    output logic                 borrow_o,
    output logic [NUM_FLAGS-1:0] flags_o
);

    localparam int unsigned Lsb = Index * Chunk;

    logic [Chunk-1:0]     x_chunk;
    logic [Chunk-1:0]     y_chunk;
    logic [Chunk:0]       chunk_res;
    logic [Bits-1:0]      diff_d;
    logic [NUM_FLAGS-1:0] flags_d;

    logic                 valid_q;
    logic [Bits-1:0]      x_q;
    logic [Bits-1:0]      y_q;
    logic [Bits-1:0]      diff_q;
    logic                 borrow_q;
    logic [NUM_FLAGS-1:0] flags_q;

    // The extra MSB of chunk_res is the borrow out of this chunk.
    always_comb begin
        x_chunk   = x_i[Lsb +: Chunk];
        y_chunk   = y_i[Lsb +: Chunk];
        chunk_res = {1'b0, x_chunk} - {1'b0, y_chunk} - {{Chunk{1'b0}}, borrow_i};
        diff_d    = diff_i;
        diff_d[Lsb +: Chunk] = chunk_res[Chunk-1:0];
        // Only meaningful in the top stage, where diff_d holds every chunk.
        flags_d   = pack_flags(diff_d[Bits-1],
                               diff_d == '0,
                               ~chunk_res[Chunk],
                               (x_i[Bits-1] != y_i[Bits-1]) &&
                               (diff_d[Bits-1] != x_i[Bits-1]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            flags_q  <= '0;
        end else if (en_i) begin
            valid_q  <= valid_i;
            x_q      <= x_i;
            y_q      <= y_i;
            diff_q   <= diff_d;
            borrow_q <= chunk_res[Chunk];
            flags_q  <= flags_d;
        end
    end

    assign valid_o  = valid_q;
    assign x_o      = x_q;
    assign y_o      = y_q;
    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;
    assign flags_o  = flags_q;

endmodule

// File: rtl/pipelined_n_bits_subtractor_module.sv
// Pipelined N-bit ARM subtractor (SUB/RSB/SBC/RSC) with NZCV flags.
// One CHUNK-bit slice per stage, borrow registered between stages.
module pipelined_n_bits_subtractor_module
    import pipelined_n_bits_subtractor_module_pkg::*;
#(
    parameter int unsigned BITS  = 32,
    parameter int unsigned CHUNK = 8
) (
    input logic                                clk,
    input logic                                rst,
    pipelined_n_bits_subtractor_module_if.slave bus
);

    localparam int unsigned STAGES = BITS / CHUNK;

    logic            stall;
    logic            accept;
    logic            reverse;
    logic            with_carry;
    logic [BITS-1:0] x_sel;
    logic [BITS-1:0] y_sel;
    logic            borrow_sel;

    logic                 valid_s  [STAGES];
    logic [BITS-1:0]      x_s      [STAGES];
    logic [BITS-1:0]      y_s      [STAGES];
    logic [BITS-1:0]      diff_s   [STAGES];
    logic                 borrow_s [STAGES];
    logic [NUM_FLAGS-1:0] flags_s  [STAGES];

    assign stall  = valid_s[STAGES-1] && !bus.out_ready;
    assign accept = bus.in_valid && !stall;

    always_comb begin
        reverse    = bus.mode inside {RSB, RSC};
        with_carry = bus.mode inside {SBC, RSC};
        x_sel      = reverse ? bus.B : bus.A;
        y_sel      = reverse ? bus.A : bus.B;
        // ARM carry is an inverted borrow.
        borrow_sel = with_carry ? ~bus.c_in : 1'b0;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic            valid_in;
        logic [BITS-1:0] x_in;
        logic [BITS-1:0] y_in;
        logic [BITS-1:0] diff_in;
        logic            borrow_in;

        if (k == 0) begin : g_first
            assign valid_in  = accept;
            assign x_in      = x_sel;
            assign y_in      = y_sel;
            assign diff_in   = '0;
            assign borrow_in = borrow_sel;
        end else begin : g_next
            assign valid_in  = valid_s[k-1];
            assign x_in      = x_s[k-1];
            assign y_in      = y_s[k-1];
            assign diff_in   = diff_s[k-1];
            assign borrow_in = borrow_s[k-1];
        end

        sub_chunk_stage #(
            .Bits  (BITS),
            .Chunk (CHUNK),
            .Index (k)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .en_i     (!stall),
            .valid_i  (valid_in),
            .x_i      (x_in),
            .y_i      (y_in),
            .diff_i   (diff_in),
            .borrow_i (borrow_in),
            .valid_o  (valid_s[k]),
            .x_o      (x_s[k]),
            .y_o      (y_s[k]),
            .diff_o   (diff_s[k]),
            .borrow_o (borrow_s[k]),
            .flags_o  (flags_s[k])
        );
    end

    assign bus.in_ready  = !stall;
    assign bus.out_valid = valid_s[STAGES-1];
    assign bus.Diff      = diff_s[STAGES-1];
    assign bus.Bout      = borrow_s[STAGES-1];
    assign bus.flags     = flags_s[STAGES-1];

    // Operands past the top stage and flags of lower stages have no consumer.
    logic unused_sigs;
    always_comb begin
        unused_sigs = ^{x_s[STAGES-1], y_s[STAGES-1]};
        for (int k = 0; k < int'(STAGES) - 1; k++) begin
            unused_sigs = unused_sigs ^ (^flags_s[k]);
        end
    end

endmodule

// File: tb/tb_pipelined_n_bits_subtractor_module.sv
// Scoreboard bench for the pipelined subtractor, BITS=8 / CHUNK=4 (2 stages).
module tb_pipelined_n_bits_subtractor_module;
    import pipelined_n_bits_subtractor_module_pkg::*;

    localparam int unsigned BITS  = 8;
    localparam int unsigned CHUNK = 4;

    logic clk;
    logic rst;

    pipelined_n_bits_subtractor_module_if #(.BITS(BITS)) bus ();

    pipelined_n_bits_subtractor_module #(
        .BITS  (BITS),
        .CHUNK (CHUNK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int run_len  = 0;
    logic [12:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference: plain 9-bit subtract, packed as {Diff, Bout, N, Z, C, V}.
    function automatic logic [12:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input sub_mode_t m, input logic cin);
        logic [7:0] x;
        logic [7:0] y;
        logic       bin;
        logic [8:0] full;
        x    = (m == RSB || m == RSC) ? b : a;
        y    = (m == RSB || m == RSC) ? a : b;
        bin  = (m == SBC || m == RSC) ? !cin : 1'b0;
        full = {1'b0, x} - {1'b0, y} - {8'b0, bin};
        return {full[7:0], full[8], full[7], full[7:0] == 8'h00, !full[8],
                (x[7] != y[7]) && (full[7] != x[7])};
    endfunction

    function automatic logic [12:0] observed();
        return {bus.Diff, bus.Bout, bus.flags};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input sub_mode_t m,
                        input logic cin, input logic [12:0] exp);
        int waited = 0;
        bus.A        = a;
        bus.B        = b;
        bus.mode     = m;
        bus.c_in     = cin;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && waited < 20) begin
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            #1;
            waited++;
        end
        if (!bus.in_ready) check("send_timeout", 32'(bus.in_ready), 32'd1);
        else exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [7:0] a, input logic [7:0] b, input sub_mode_t m,
                              input logic cin);
        send(a, b, m, cin, model(a, b, m, cin));
    endtask

    task automatic check_latency(input string tag);
        int cyc = 1;
        while (!bus.out_valid && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check(tag, 32'(cyc), 32'd2);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            run_len++;
            if (exp_q.size() == 0) check("pending_results", 32'(exp_q.size() != 0), 32'd1);
            else check("result", 32'(observed()), 32'(exp_q.pop_front()));
        end else begin
            run_len = 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0] snap;
        int          waited;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.mode      = SUB;
        bus.c_in      = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_outputs", 32'(observed()), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed cases with hand-derived results.
        send(8'h05, 8'h03, SUB, 1'b0, {8'h02, 1'b0, 4'b0010});
        check_latency("latency_first");
        send(8'h03, 8'h05, SUB, 1'b0, {8'hFE, 1'b1, 4'b1000});
        send(8'h80, 8'h01, SUB, 1'b0, {8'h7F, 1'b0, 4'b0011});
        send(8'h01, 8'h01, RSB, 1'b0, {8'h00, 1'b0, 4'b0110});
        send(8'h10, 8'h00, SBC, 1'b0, {8'h0F, 1'b0, 4'b0010});
        send(8'h01, 8'h10, RSC, 1'b1, {8'h0F, 1'b0, 4'b0010});
        repeat (4) @(posedge clk);
        #1;

        // Four back-to-back operations must exit on four consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            send_model(8'($urandom), 8'($urandom), sub_mode_t'($urandom_range(0, 3)),
                       1'($urandom));
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        check("burst_run", 32'(run_len), 32'd4);
        @(posedge clk);
        #1;

        // Stall: two results queued behind out_ready=0, junk input ignored.
        bus.out_ready = 1'b0;
        send_model(8'h3C, 8'hC3, SUB, 1'b0);
        send_model(8'h00, 8'h01, RSC, 1'b0);
        snap = observed();
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        bus.A        = 8'hAA;
        bus.B        = 8'h55;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_hold", 32'(observed()), 32'(snap));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("stall_drain", 32'(exp_q.size()), 32'd0);

        // Reset with two operations in flight discards them.
        bus.out_ready = 1'b0;
        send_model(8'h12, 8'h34, SUB, 1'b0);
        send_model(8'h56, 8'h78, SBC, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_outputs", 32'(observed()), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        bus.out_ready = 1'b1;
        send_model(8'h00, 8'h01, SUB, 1'b0);
        check_latency("latency_after_rst");
        repeat (3) @(posedge clk);
        #1;

        // Random traffic with random backpressure.
        for (int i = 0; i < 24; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            send_model(8'($urandom), 8'($urandom), sub_mode_t'($urandom_range(0, 3)),
                       1'($urandom));
        end
        bus.out_ready = 1'b1;
        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("final_drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("idle_out_valid", 32'(bus.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipelined_n_bits_subtractor_module.md
Name: pipelined_n_bits_subtractor_module

Overview:
Parametrised, pipelined successor to the combinational N-bit ripple subtractor. The operand is split into CHUNK-bit slices, one slice per pipeline stage, with the borrow registered between stages. Supports the four ARM subtract modes (SUB, RSB, SBC, RSC) and produces ARM NZCV flags. It sits in the datapath ALU, behind a valid/ready handshake, so the borrow chain no longer limits Fmax.

Parameters:
BITS, 32, operand/result width; must be a multiple of CHUNK.
CHUNK, 8, bits resolved per stage; STAGES = BITS/CHUNK, must be >= 1.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands/mode valid this cycle.
in_ready  output  1  block accepts input this cycle.
A  input  BITS  first operand.
B  input  BITS  second operand.
mode  input  2  00 SUB A-B; 01 RSB B-A; 10 SBC A-B-!c_in; 11 RSC B-A-!c_in.
c_in  input  1  ARM carry flag; used only by SBC/RSC.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
Diff  output  BITS  difference, modulo 2^BITS.
Bout  output  1  final borrow out of MSB.
flags  output  4  {N,Z,C,V}.

Behaviour:
- Reset, sampled on clk edge while rst=1: out_valid=0, Diff=0, Bout=0, flags=0, all stage valid bits=0, all in-flight operations discarded. rst dominates every other input, including mid-operation.
- Operand select at input:
  - X=A, Y=B for SUB/SBC; X=B, Y=A for RSB/RSC.
  - Initial borrow = 0 for SUB/RSB; !c_in for SBC/RSC.
- Stage k (0..STAGES-1) computes chunk k: X[k] - Y[k] - borrow_k.
  - It registers the chunk result, the borrow out, and the not-yet-processed upper chunks of X and Y (skewed pipeline).
  - Lower result chunks are delayed alongside, so all chunks of one operation exit together.
- Latency: exactly STAGES cycles from the accepting edge (in_valid && in_ready) to out_valid=1, absent stalls. Throughput is 1 operation per cycle.
- Handshake:
  - stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stalled, every stage register and all outputs hold.
  - in_valid while in_ready=0 is ignored; the source must hold its data.
  - out_valid drops the cycle after a transfer unless a new result arrives.
- Flags, computed in the final stage:
  - N = Diff[BITS-1].
  - Z = (Diff==0).
  - C = !Bout (ARM: no borrow ⇒ C=1).
  - V = (X[BITS-1] != Y[BITS-1]) && (Diff[BITS-1] != X[BITS-1]).
- Wrap-around: results are modulo 2^BITS; the borrow is reported, never saturated.
- STAGES=1 degenerates to a single registered full-width subtract with latency 1.
- Simultaneous input accept and output transfer in the same cycle is legal and required for full throughput.
- Outputs are stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package: sub_mode_t enum (SUB, RSB, SBC, RSC); flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One natural sub-module: sub_chunk_stage, a CHUNK-bit subtract with borrow-in/out plus its pipeline register and hold-on-stall enable.
- Generate STAGES instances; the existing full-subtractor cell may implement the chunk arithmetic.

Test Plan:
1. BITS=8, CHUNK=4, SUB, A=0x05, B=0x03 -> after 2 cycles: Diff=0x02, Bout=0, flags N0 Z0 C1 V0.
2. SUB, A=0x03, B=0x05 -> Diff=0xFE, Bout=1, N1 Z0 C0 V0; the borrow crosses the chunk boundary correctly.
3. SUB, A=0x80, B=0x01 -> Diff=0x7F, N0 C1 V1. RSB, A=0x01, B=0x01 -> Diff=0x00, Z1 C1.
4. SBC, A=0x10, B=0x00, c_in=0 -> Diff=0x0F, C1. RSC, A=0x01, B=0x10, c_in=1 -> Diff=0x0F.
5. Back-to-back: 4 operations on consecutive cycles with out_ready=1 -> 4 consecutive out_valid cycles with in-order results. Then hold out_ready=0 for 3 cycles -> in_ready=0, outputs frozen, no result lost or duplicated on release.
6. Assert rst for one cycle with 2 operations in flight -> next cycle out_valid=0, all outputs 0. A fresh operation then completes with correct latency.
